// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a command/response port
module axi_lite_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      s_aclk,
  input  logic                      s_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0] state;
  logic       aw_done;
  logic       w_done;
  logic       aw_hs;
  logic       w_hs;

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // Handshakes on the two write-request channels, tracked independently
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  // Transaction sequencer: one command in, one AXI transaction, one completion out
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_write    <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed and randomized bench for axi_lite_master with a BRAM-style responder
module tb_axi_lite_master;

  logic        s_aclk;
  logic        s_aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_master dut (
    .s_aclk(s_aclk), .s_aresetn(s_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Responder configuration and BRAM storage
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_cfg = 2'b00, r_cfg = 2'b00;
  logic [31:0] bram [0:63];
  logic [15:0] last_awaddr, last_araddr;

  // Responder: decides readies/valids on the falling edge; a raised ready
  // guarantees a handshake at the next rising edge because valid may not drop.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, b_pend, r_pend, in_rst;
    logic [15:0] wa, ra;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [15:0] p_awa, p_ara;
    logic [31:0] p_wd;
    for (int i = 0; i < 64; i++) bram[i] = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; in_rst = 1;
    wa = 0; ra = 0; wd = 0; ws = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awa = 0; p_ara = 0; p_wd = 0;
    last_awaddr = 0; last_araddr = 0;
    forever begin
      @(negedge s_aclk);
      if (!s_aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; in_rst = 1;
      end else begin
        if (!in_rst) begin
          if (p_awv && !p_awr) chk("aw_valid_hold", {awvalid, awaddr}, {1'b1, p_awa});
          if (p_wv && !p_wr)   chk("w_valid_hold", {wvalid, wdata}, {1'b1, p_wd});
          if (p_arv && !p_arr) chk("ar_valid_hold", {arvalid, araddr}, {1'b1, p_ara});
        end
        in_rst = 0;
        if (awready) awready = 0;
        else if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_dly) begin
            awready = 1; aw_got = 1; wa = awaddr; last_awaddr = awaddr; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (wready) wready = 0;
        else if (wvalid && !w_got) begin
          if (w_cnt >= w_dly) begin
            wready = 1; w_got = 1; wd = wdata; ws = wstrb; w_cnt = 0;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin
          bram[wa[7:2]] = merge(bram[wa[7:2]], wd, ws);
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (bvalid) bvalid = 0;
        else if (b_pend && bready) begin
          if (b_cnt >= b_dly) begin
            bvalid = 1; bresp = b_cfg; b_pend = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (arready) arready = 0;
        else if (arvalid && !r_pend) begin
          if (ar_cnt >= ar_dly) begin
            arready = 1; ra = araddr; last_araddr = araddr; r_pend = 1; ar_cnt = 0; r_cnt = 0;
          end else ar_cnt++;
        end
        if (rvalid) rvalid = 0;
        else if (r_pend && rready) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1; rdata = bram[ra[7:2]]; rresp = r_cfg; r_pend = 0; r_cnt = 0;
          end else r_cnt++;
        end
      end
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid;   p_wr = wready;   p_wd = wdata;
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
    end
  end

  // Reference memory: what every word should hold after the commands issued so far
  logic [31:0] ref_mem [0:63];

  task automatic step();
    @(negedge s_aclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    step();
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input string tag, input logic w, input logic [31:0] er, input logic [1:0] eresp, input int hold);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin step(); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold"}, {rsp_valid, cmd_ready, busy, rsp_write, rsp_resp, rsp_rdata},
          {1'b1, 1'b0, 1'b1, w, eresp, er});
      step();
    end
    chk({tag, "_rsp_fields"}, {rsp_write, rsp_resp, rsp_rdata}, {w, eresp, er});
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk({tag, "_idle_after"}, {rsp_valid, cmd_ready, busy}, {1'b0, 1'b1, 1'b0});
  endtask

  task automatic predict(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] er);
    if (w) begin
      ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
      er = 32'h0;
    end else er = ref_mem[a[7:2]];
  endtask

  task automatic run(input string tag, input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] resp, input int hold);
    logic [31:0] er;
    b_cfg = resp; r_cfg = resp;
    predict(w, a, d, s, er);
    issue(w, a, d, s);
    wait_rsp(tag, w, er, resp, hold);
    if (w) chk({tag, "_awaddr"}, last_awaddr, a);
    else   chk({tag, "_araddr"}, last_araddr, a);
  endtask

  initial begin
    logic [31:0] er;
    logic        rw;
    logic [15:0] ra;
    logic [31:0] rd;
    logic [3:0]  rs;
    logic [1:0]  rr;
    int          n;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    s_aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    step(); step();
    chk("reset_outputs", {cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_regs", {awaddr, araddr, rsp_rdata, rsp_resp, awprot, arprot}, '0);
    s_aresetn = 1;
    step();

    // Zero-wait write with exact cycle positions
    predict(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, er);
    issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    chk("t1_c1_aw_w", {awvalid, awready, wvalid, wready, awaddr, wdata, wstrb},
        {1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF});
    step();
    chk("t1_c2_b", {awvalid, wvalid, bready, bvalid, rsp_valid}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    step();
    chk("t1_c3_rsp", {rsp_valid, bready}, {1'b1, 1'b0});
    wait_rsp("t1", 1'b1, 32'h0, 2'b00, 0);

    // Read back the same word
    run("t2", 1'b0, 16'h0004, 32'h0, 4'h0, 2'b00, 0);

    // Skewed write: AW accepted four cycles after W
    aw_dly = 4; w_dly = 0;
    predict(1'b1, 16'h0008, 32'h12345678, 4'hF, er);
    issue(1'b1, 16'h0008, 32'h12345678, 4'hF);
    chk("t3_c1", {awvalid, awready, wvalid, wready}, {1'b1, 1'b0, 1'b1, 1'b1});
    step();
    chk("t3_c2", {awvalid, wvalid, bready}, {1'b1, 1'b0, 1'b0});
    step(); step(); step();
    chk("t3_c5", {awvalid, awready, bready}, {1'b1, 1'b1, 1'b0});
    step();
    chk("t3_c6", {awvalid, bready}, {1'b0, 1'b1});
    wait_rsp("t3", 1'b1, 32'h0, 2'b00, 0);
    aw_dly = 0;

    // Response backpressure with SLVERR
    run("t4", 1'b1, 16'h000C, 32'hCAFEF00D, 4'h5, 2'b10, 10);

    // Reset while waiting for read data
    r_dly = 50;
    issue(1'b0, 16'h0008, 32'h0, 4'h0);
    n = 0;
    while (!rready && n < 20) begin step(); n++; end
    chk("t5_in_rd_data", {rready, busy}, {1'b1, 1'b1});
    s_aresetn = 0;
    #1;
    chk("t5_reset", {arvalid, rready, rsp_valid, busy, cmd_ready, rsp_rdata},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    step();
    s_aresetn = 1;
    r_dly = 0;
    step();
    chk("t5_no_completion", rsp_valid, 1'b0);
    run("t5_after", 1'b0, 16'h0008, 32'h0, 4'h0, 2'b00, 0);

    // Randomized traffic with wait states, unaligned addresses and random responses
    for (int t = 0; t < 16; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      rw = 1'($urandom_range(0, 1));
      ra = {8'h00, 8'($urandom_range(0, 255))};
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      rr = 2'($urandom_range(0, 3));
      run($sformatf("rnd%0d", t), rw, ra, rd, rs, rr, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
